uart_console_rx: RTL

Serial-to-character front end for the text console, in the `CLK_DATA` domain, directly upstream of the VGA console top.
- Receives 8N1 UART bytes with 16× oversampling.
- Collapses CR-LF pairs and presents each printable/control byte as a one-cycle `data`/`data_en` strobe.
- Decodes the escape sequence `ESC 'G' rows cols` into `max_rows`/`max_columns` with a one-cycle `row_column_update` pulse.
- Has no backpressure: the console accepts one byte per cycle, and bytes arrive at most once per 160·DIV cycles.

---
 rtl/console_pkg.sv | 29 ++
 rtl/uart_rx_core.sv | 84 ++++++++
 rtl/uart_console_rx.sv | 83 ++++++++
 3 files changed

// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared state encodings and character constants for the UART console front end
package console_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    P_TEXT,
    P_ESC,
    P_ROWS,
    P_COLS
  } parse_state_t;

  localparam logic [7:0] CHR_CR   = 8'h0D;
  localparam logic [7:0] CHR_LF   = 8'h0A;
  localparam logic [7:0] CHR_ESC  = 8'h1B;
  localparam logic [7:0] CHR_GEOM = 8'h47;

  // Sample points in oversample ticks counted from start detection.
  localparam logic [7:0] S_START    = 8'd7;
  localparam logic [7:0] S_LAST_BIT = 8'd135;
  localparam logic [7:0] S_STOP     = 8'd151;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver with 2-flop synchronizer and 16x oversampling
module uart_rx_core
  import console_pkg::*;
#(
  parameter int DIV = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  logic [1:0]    sync;
  logic          line;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [7:0]    s;
  logic [7:0]    shreg;
  rx_state_t     state;

  assign line = sync[1];
  assign tick = (tcnt == TICK_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync     <= 2'b11;
      tcnt     <= '0;
      s        <= '0;
      shreg    <= '0;
      state    <= RX_IDLE;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      sync     <= {sync[0], rxd};
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      tcnt     <= tick ? '0 : tcnt + 1'b1;
      if (tick) s <= s + 8'd1;

      case (state)
        RX_IDLE: begin
          // Re-phase the tick counter to the start edge.
          if (!line) begin
            state <= RX_START;
            s     <= '0;
            tcnt  <= '0;
          end
        end
        RX_START: begin
          if (tick && s == S_START) state <= line ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          if (tick && s[3:0] == 4'd7) begin
            shreg <= {line, shreg[7:1]};
            if (s == S_LAST_BIT) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (tick && s == S_STOP) begin
            if (line) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
              state    <= RX_IDLE;
            end else begin
              rx_ferr <= 1'b1;
              state   <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          if (line) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_console_rx.sv
// rtl/uart_console_rx.sv - UART console receiver: CR-LF collapse and ESC 'G' geometry decode
module uart_console_rx
  import console_pkg::*;
#(
  parameter int         DIV      = 27,
  parameter logic [7:0] DEF_ROWS = 8'h80,
  parameter logic [7:0] DEF_COLS = 8'hA0
) (
  input  logic       CLK_DATA,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_en,
  output logic [7:0] max_rows,
  output logic [7:0] max_columns,
  output logic       row_column_update,
  output logic       frame_err
);

  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         rx_ferr;
  logic         crlf;
  logic [7:0]   pend_rows;
  parse_state_t pstate;

  uart_rx_core #(.DIV(DIV)) u_core (
    .clk      (CLK_DATA),
    .reset    (reset),
    .rxd      (rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  // The core's error pulse is already registered; forwarding it keeps the 1-cycle latency.
  assign frame_err = rx_ferr;

  always_ff @(posedge CLK_DATA) begin
    if (!reset) begin
      data              <= '0;
      data_en           <= 1'b0;
      max_rows          <= DEF_ROWS;
      max_columns       <= DEF_COLS;
      row_column_update <= 1'b0;
      crlf              <= 1'b0;
      pend_rows         <= '0;
      pstate            <= P_TEXT;
    end else begin
      data_en           <= 1'b0;
      row_column_update <= 1'b0;
      if (rx_valid) begin
        crlf <= 1'b0;
        case (pstate)
          P_TEXT: begin
            if (rx_byte == CHR_ESC) begin
              pstate <= P_ESC;
            end else if (!(rx_byte == CHR_LF && crlf)) begin
              data    <= rx_byte;
              data_en <= 1'b1;
              crlf    <= (rx_byte == CHR_CR);
            end
          end
          P_ESC: pstate <= (rx_byte == CHR_GEOM) ? P_ROWS : P_TEXT;
          P_ROWS: begin
            pend_rows <= rx_byte;
            pstate    <= P_COLS;
          end
          P_COLS: begin
            if (pend_rows != 8'd0 && rx_byte != 8'd0) begin
              max_rows          <= pend_rows;
              max_columns       <= rx_byte;
              row_column_update <= 1'b1;
            end
            pstate <= P_TEXT;
          end
          default: pstate <= P_TEXT;
        endcase
      end
    end
  end

endmodule
